// File: rtl/orangecrab_btn_reboot.sv
// User-button front end: sync + debounce, short-press event, long-hold sticky reboot request.
// Optional hold-progress LED output enabled by defining BTN_REBOOT_LED_EN.
module orangecrab_btn_reboot #(
  parameter int unsigned DEBOUNCE_CYCLES = 480_000,
  parameter int unsigned HOLD_CYCLES     = 96_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic short_press,
  output logic do_reset
`ifdef BTN_REBOOT_LED_EN
  ,
  output logic hold_led
`endif
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    PRESSED,
    FIRED
  } state_t;

  logic              sync0;
  logic              sync1;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;

  state_t            state;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_d;
  logic              short_d;
  logic              do_reset_d;

  // Sync flops reset to 0 so the button reads as pressed until a release is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_n;
      sync1 <= sync0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync1 != stable) begin
      if (db_cnt == DB_TERM) begin
        stable <= ~stable;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_level = ~stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DISARMED;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      do_reset    <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      short_press <= short_d;
      do_reset    <= do_reset_d;
    end
  end

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    case (state)
      DISARMED: if (!btn_level) state_d = IDLE;
      IDLE: begin
        if (btn_level) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Terminal count wins over a release in the same cycle.
        if (hold_cnt == HOLD_TERM) begin
          state_d = FIRED;
        end else begin
          hold_d = hold_cnt + 1'b1;
          if (!btn_level) state_d = IDLE;
        end
      end
      FIRED:   state_d = FIRED;
      default: state_d = DISARMED;
    endcase
  end

  always_comb begin
    short_d    = (state == PRESSED) && (hold_cnt != HOLD_TERM) && !btn_level;
    do_reset_d = (state_d == FIRED);
  end

`ifdef BTN_REBOOT_LED_EN
  localparam int unsigned LED_BIT = ($clog2(HOLD_CYCLES) > 3) ? ($clog2(HOLD_CYCLES) - 3) : 0;

  logic hold_led_d;

  always_comb begin
    hold_led_d = 1'b0;
    case (state_d)
      PRESSED: hold_led_d = hold_d[LED_BIT];
      FIRED:   hold_led_d = 1'b1;
      default: hold_led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) hold_led <= 1'b0;
    else     hold_led <= hold_led_d;
  end
`endif

endmodule

// File: tb/tb_orangecrab_btn_reboot.sv
// Bench for orangecrab_btn_reboot with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16 against a cycle-count model.
module tb_orangecrab_btn_reboot;

  localparam int unsigned DEB     = 4;
  localparam int unsigned HOLD    = 16;
  localparam int unsigned LED_SH  = 1;
  localparam int unsigned HIST_N  = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic btn_level;
  logic short_press;
  logic do_reset;
  logic led_w;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

`ifdef BTN_REBOOT_LED_EN
  logic hold_led_s;
  orangecrab_btn_reboot #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_level(btn_level),
    .short_press(short_press), .do_reset(do_reset), .hold_led(hold_led_s)
  );
  assign led_w = hold_led_s;
`else
  orangecrab_btn_reboot #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_level(btn_level),
    .short_press(short_press), .do_reset(do_reset)
  );
  assign led_w = 1'b0;
`endif

  // Reference: raw history delayed two samples, run-length debounce, press timed in elapsed cycles.
  bit          hist [0:HIST_N-1];
  int unsigned m_cyc = 0;
  int unsigned m_since = 0;
  int unsigned m_run = 0;
  int unsigned m_elapsed = 0;
  bit          m_level = 1'b1;
  bit          m_armed = 1'b0;
  bit          m_pressing = 1'b0;
  bit          m_fired = 1'b0;
  bit          m_short = 1'b0;
  bit          m_led = 1'b0;
  logic        exp_led;

`ifdef BTN_REBOOT_LED_EN
  assign exp_led = m_led;
`else
  assign exp_led = 1'b0;
`endif

  logic [3:0] obs, exp_v;
  assign obs   = {btn_level, short_press, do_reset, led_w};
  assign exp_v = {m_level, m_short, m_fired, exp_led};

  always @(posedge clk) begin : model_p
    automatic bit          synced;
    automatic bit          lvl;
    automatic bit          armed;
    automatic bit          pressing;
    automatic bit          fired;
    automatic bit          short_e;
    automatic int unsigned run;
    automatic int unsigned el;
    hist[m_cyc % HIST_N] <= btn_n;
    m_cyc <= m_cyc + 1;
    if (rst) begin
      m_since <= 0; m_run <= 0; m_elapsed <= 0; m_level <= 1'b1;
      m_armed <= 1'b0; m_pressing <= 1'b0; m_fired <= 1'b0;
      m_short <= 1'b0; m_led <= 1'b0;
    end else begin
      synced   = (m_since >= 2) ? hist[(m_cyc - 2) % HIST_N] : 1'b0;
      lvl      = m_level;
      run      = m_run;
      armed    = m_armed;
      pressing = m_pressing;
      fired    = m_fired;
      el       = m_elapsed;
      short_e  = 1'b0;
      if ((!synced) != m_level) run++;
      else run = 0;
      if (run == DEB) begin
        lvl = !lvl;
        run = 0;
      end
      if (fired) begin
      end else if (!armed) begin
        armed = !m_level;
      end else if (!pressing) begin
        if (m_level) begin
          pressing = 1'b1;
          el = 0;
        end
      end else begin
        el++;
        if (el == HOLD) begin
          fired = 1'b1;
          pressing = 1'b0;
        end else if (!m_level) begin
          pressing = 1'b0;
          short_e = 1'b1;
        end
      end
      m_since    <= m_since + 1;
      m_run      <= run;
      m_level    <= lvl;
      m_armed    <= armed;
      m_pressing <= pressing;
      m_fired    <= fired;
      m_elapsed  <= el;
      m_short    <= short_e;
      m_led      <= fired ? 1'b1 : (pressing ? (((el >> LED_SH) & 1) != 0) : 1'b0);
    end
  end

  task automatic apply_reset(input bit btn_val);
    rst = 1'b1;
    btn_n = btn_val;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({btn_level, short_press, do_reset, led_w} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_values: got %b expected 1000", {btn_level, short_press, do_reset, led_w});
    end
    rst = 1'b0;
    n = 0;
    while (btn_level !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_cycle: got %b expected %b", obs, exp_v);
      end
    end
    checks++;
    if (btn_level !== 1'b0 || n > 2 + DEB + 1) begin
      fails++;
      $display("FAIL release_latency: got level %b after %0d cycles, required 0 within %0d", btn_level, n, 2 + DEB + 1);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_settle: got %b expected %b", obs, exp_v);
      end
    end
  endtask

  task automatic test_held_at_reset;
    int shorts;
    apply_reset(1'b0);
    shorts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      shorts += int'(short_press);
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL held_cycle: got %b expected %b", obs, exp_v);
      end
    end
    checks++;
    if (shorts != 0 || do_reset !== 1'b0) begin
      fails++;
      $display("FAIL held_no_action: got shorts=%0d do_reset=%b required 0/0", shorts, do_reset);
    end
    for (int i = 0; i < 38; i++) begin
      btn_n = (i < 12) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL held_rearm_cycle: got %b expected %b", obs, exp_v);
      end
    end
    checks++;
    if (do_reset !== 1'b1) begin
      fails++;
      $display("FAIL held_then_hold: got do_reset=%b required 1", do_reset);
    end
    btn_n = 1'b1;
  endtask

  task automatic test_glitch;
    int unsigned len;
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    for (int g = 0; g < 12; g++) begin
      len = $urandom_range(1, DEB - 1);
      for (int i = 0; i < int'(len) + 6; i++) begin
        btn_n = (i < int'(len)) ? 1'b0 : 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp_v || btn_level !== 1'b0) begin
          fails++;
          $display("FAIL glitch len=%0d: got %b expected %b (level must stay 0)", len, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_short_press;
    int unsigned len;
    int shorts;
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      len = (k == 0) ? 10 : $urandom_range(DEB + 1, 12);
      shorts = 0;
      for (int i = 0; i < int'(len) + 16; i++) begin
        btn_n = (i < int'(len)) ? 1'b0 : 1'b1;
        @(negedge clk);
        shorts += int'(short_press);
        checks++;
        if (obs !== exp_v) begin
          fails++;
          $display("FAIL short_cycle len=%0d: got %b expected %b", len, obs, exp_v);
        end
      end
      checks++;
      if (shorts != 1 || do_reset !== 1'b0) begin
        fails++;
        $display("FAIL short_count len=%0d: got shorts=%0d do_reset=%b required 1/0", len, shorts, do_reset);
      end
    end
  endtask

  task automatic test_long_hold;
    int t_lvl, t_rst, shorts;
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    t_lvl = -1;
    t_rst = -1;
    shorts = 0;
    btn_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (btn_level === 1'b1 && t_lvl < 0) t_lvl = i;
      if (do_reset === 1'b1 && t_rst < 0) t_rst = i;
      shorts += int'(short_press);
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL hold_cycle: got %b expected %b", obs, exp_v);
      end
    end
    checks++;
    if (t_lvl < 0 || t_rst < 0 || (t_rst - t_lvl) != HOLD + 1) begin
      fails++;
      $display("FAIL hold_latency: got level@%0d do_reset@%0d, required gap %0d", t_lvl, t_rst, HOLD + 1);
    end
    for (int i = 0; i < 60; i++) begin
      btn_n = (i >= 15 && i < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      shorts += int'(short_press);
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL hold_after_cycle: got %b expected %b", obs, exp_v);
      end
    end
    checks++;
    if (do_reset !== 1'b1 || shorts != 0) begin
      fails++;
      $display("FAIL hold_sticky: got do_reset=%b shorts=%0d required 1/0", do_reset, shorts);
    end
    apply_reset(1'b1);
    @(negedge clk);
    checks++;
    if (do_reset !== 1'b0) begin
      fails++;
      $display("FAIL hold_cleared: got do_reset=%b required 0", do_reset);
    end
  endtask

  task automatic test_rst_mid_hold;
    bit hit;
    int toggles;
    logic prev_led;
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    btn_n = 1'b0;
    hit = 1'b0;
    toggles = 0;
    prev_led = led_w;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (led_w !== prev_led) toggles++;
      prev_led = led_w;
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL midhold_cycle: got %b expected %b", obs, exp_v);
      end
      if (m_pressing && m_elapsed == 10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL midhold_timeout: hold count 10 not reached, do_reset=%b", do_reset);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({btn_level, short_press, do_reset, led_w} !== 4'b1000) begin
      fails++;
      $display("FAIL midhold_reset: got %b expected 1000", {btn_level, short_press, do_reset, led_w});
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v || do_reset !== 1'b0 || short_press !== 1'b0) begin
        fails++;
        $display("FAIL midhold_after: got %b expected %b", obs, exp_v);
      end
    end
`ifdef BTN_REBOOT_LED_EN
    checks++;
    if (toggles < 2) begin
      fails++;
      $display("FAIL midhold_led_toggle: got %0d toggles required >= 2", toggles);
    end
`endif
    btn_n = 1'b1;
  endtask

  task automatic test_random;
    int unsigned run;
    apply_reset($urandom_range(0, 1) != 0);
    for (int r = 0; r < 40; r++) begin
      btn_n = ~btn_n;
      run = $urandom_range(1, 22);
      for (int i = 0; i < int'(run); i++) begin
        @(negedge clk);
        checks++;
        if (obs !== exp_v) begin
          fails++;
          $display("FAIL random_cycle run=%0d: got %b expected %b", run, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_held_at_reset();
    test_glitch();
    test_short_press();
    test_long_hold();
    test_rst_mid_hold();
    for (int k = 0; k < 4; k++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
